// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - program counter, line fetch and halfword issue to decode
//
// Holds the PC and presents a line-aligned fetch address to instruction memory.
// The returned 64-bit line is captured on a memory change pulse, or after a
// bounded wait. Instructions from that line are then handed out one 16-bit
// halfword per valid/ready handshake. Redirects take priority over everything
// else, and skip the refetch when the target lies in the buffered line.
//
// Ports:
//   inp_clk              clock, all state on rising edge
//   inp_rst              synchronous reset, active-high
//   inp_memDataLine      64-bit line from instruction memory for out_memAddress
//   inp_memAddressChange one-cycle pulse: inp_memDataLine reflects the new address
//   out_memAddress       line-aligned fetch address {pc[15:3],3'b000}
//   out_instr            current instruction (little-endian halfword of the line)
//   out_instrPc          byte address of out_instr
//   out_instrValid       out_instr/out_instrPc valid
//   inp_instrReady       decode accepts when valid & ready
//   inp_redirect         one-cycle redirect request
//   inp_redirectPc       redirect target, bit 0 ignored

module instruction_fetch_buffer #(
  parameter logic [15:0] RESET_PC      = 16'd256,
  parameter int unsigned FETCH_TIMEOUT = 4
) (
  input  logic        inp_clk,
  input  logic        inp_rst,
  input  logic [63:0] inp_memDataLine,
  input  logic        inp_memAddressChange,
  output logic [15:0] out_memAddress,
  output logic [15:0] out_instr,
  output logic [15:0] out_instrPc,
  output logic        out_instrValid,
  input  logic        inp_instrReady,
  input  logic        inp_redirect,
  input  logic [15:0] inp_redirectPc
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Last count value of the FETCH wait; capture happens on the cycle it is seen.
  localparam logic [3:0] TO_LAST = 4'(FETCH_TIMEOUT - 1);

  state_t      state_q,      state_d;
  logic [15:0] pc_q,         pc_d;
  logic [63:0] line_q,       line_d;
  logic [12:0] line_tag_q,   line_tag_d;
  logic        line_valid_q, line_valid_d;
  logic [3:0]  to_cnt_q,     to_cnt_d;

  logic [15:0] redir_pc;
  logic        redir_hit;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    line_d       = line_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    to_cnt_d     = to_cnt_q;

    redir_pc  = inp_redirectPc & 16'hFFFE;
    redir_hit = line_valid_q && (redir_pc[15:3] == line_tag_q);

    if (inp_redirect) begin
      // A handshake in the same cycle is dropped: the PC jumps to the target only.
      pc_d = redir_pc;
      if (redir_hit) begin
        // Memory will not pulse for an unchanged line, so serve from the buffer.
        state_d = ST_SERVE;
      end else begin
        line_valid_d = 1'b0;
        to_cnt_d     = 4'd0;
        state_d      = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          to_cnt_d = to_cnt_q + 4'd1;
          if (inp_memAddressChange || (to_cnt_q == TO_LAST)) begin
            line_d       = inp_memDataLine;
            line_tag_d   = pc_q[15:3];
            line_valid_d = 1'b1;
            to_cnt_d     = 4'd0;
            state_d      = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (inp_instrReady) begin
            pc_d = pc_q + 16'd2;
            // Last halfword of the line consumed: fetch the next line.
            if (pc_q[2:1] == 2'b11) begin
              line_valid_d = 1'b0;
              to_cnt_d     = 4'd0;
              state_d      = ST_FETCH;
            end
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      line_q       <= 64'd0;
      line_tag_q   <= 13'd0;
      line_valid_q <= 1'b0;
      to_cnt_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      line_q       <= line_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  always_comb begin
    out_instr = line_q[15:0];
    case (pc_q[2:1])
      2'd0: out_instr = line_q[15:0];
      2'd1: out_instr = line_q[31:16];
      2'd2: out_instr = line_q[47:32];
      2'd3: out_instr = line_q[63:48];
      default: out_instr = line_q[15:0];
    endcase
  end

  assign out_memAddress = {pc_q[15:3], 3'b000};
  assign out_instrPc    = pc_q;
  assign out_instrValid = (state_q == ST_SERVE);

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb/tb_instruction_fetch_buffer.sv - self-checking bench for instruction_fetch_buffer

module tb_instruction_fetch_buffer;

  localparam logic [15:0] RPC = 16'd256;
  localparam int          TO  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = 64'd0;
  logic        chg = 1'b0;
  logic [15:0] maddr, instr, ipc;
  logic        ivalid;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [15:0] rpc = 16'd0;

  int vectors = 0;
  int miscompares = 0;

  logic [48:0] obs;
  logic [32:0] obs_s;
  assign obs   = {ivalid, instr, ipc, maddr};
  assign obs_s = {ivalid, ipc, maddr};

  always #5 clk = ~clk;

  instruction_fetch_buffer #(
    .RESET_PC      (RPC),
    .FETCH_TIMEOUT (TO)
  ) dut (
    .inp_clk              (clk),
    .inp_rst              (rst),
    .inp_memDataLine      (data),
    .inp_memAddressChange (chg),
    .out_memAddress       (maddr),
    .out_instr            (instr),
    .out_instrPc          (ipc),
    .out_instrValid       (ivalid),
    .inp_instrReady       (ready),
    .inp_redirect         (redir),
    .inp_redirectPc       (rpc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    chg = 1'b0; redir = 1'b0; ready = 1'b0; rpc = 16'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] mem_line(input logic [12:0] tag);
    logic [15:0] b;
    b = {3'b000, tag};
    return {b ^ 16'hA5A5, ~b, b * 16'd3, b + 16'h1234};
  endfunction

  task automatic test_reset;
    logic [48:0] exp;
    idle_inputs();
    rst = 1'b1;
    tick();
    exp = {1'b0, 16'h0000, RPC, 16'h0100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    // reset in the middle of serving drops the line and the pending handshake
    rst = 1'b0; data = 64'h4444_3333_2222_1111; chg = 1'b1; tick();
    chg = 1'b0; ready = 1'b1; tick();
    rst = 1'b1; chg = 1'b1; tick();
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_midop: got %h want %h", obs, exp); end
    rst = 1'b0; chg = 1'b0; ready = 1'b0; tick();
    vectors++;
    if (ivalid !== 1'b0) begin miscompares++; $display("FAIL reset_release_valid: got %b want 0", ivalid); end
  endtask

  task automatic test_seq;
    logic [48:0] exp;
    logic [32:0] exps;
    do_reset();
    data = 64'h4444_3333_2222_1111; chg = 1'b1; ready = 1'b1;
    tick();
    chg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, 16'(16'h1111 * (i + 1)), 16'(256 + 2 * i), 16'h0100};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL seq_%0d: got %h want %h", i, obs, exp); end
      tick();
    end
    exps = {1'b0, 16'd264, 16'h0108};
    vectors++;
    if (obs_s !== exps) begin miscompares++; $display("FAIL seq_refetch: got %h want %h", obs_s, exps); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [48:0] exp;
    do_reset();
    data = 64'h4444_3333_2222_1111; chg = 1'b1; tick();
    chg = 1'b0; ready = 1'b1; tick();
    ready = 1'b0;
    exp = {1'b1, 16'h2222, 16'd258, 16'h0100};
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL bp_hold_%0d: got %h want %h", i, obs, exp); end
    end
    ready = 1'b1; tick(); ready = 1'b0;
    exp = {1'b1, 16'h3333, 16'd260, 16'h0100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL bp_release: got %h want %h", obs, exp); end
  endtask

  task automatic test_redirect_miss;
    logic [48:0] exp;
    logic [32:0] exps;
    do_reset();
    data = 64'h4444_3333_2222_1111; chg = 1'b1; tick();
    chg = 1'b0; redir = 1'b1; rpc = 16'h0205; tick();
    redir = 1'b0;
    exps = {1'b0, 16'h0204, 16'h0200};
    vectors++;
    if (obs_s !== exps) begin miscompares++; $display("FAIL redir_miss_fetch: got %h want %h", obs_s, exps); end
    data = 64'hDDDD_CCCC_BBBB_AAAA; chg = 1'b1; tick();
    chg = 1'b0;
    exp = {1'b1, 16'hCCCC, 16'h0204, 16'h0200};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL redir_miss_fill: got %h want %h", obs, exp); end
    // a pulse while serving is ignored
    data = 64'h1234_5678_9ABC_DEF0; chg = 1'b1; tick();
    chg = 1'b0;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL serve_pulse_ignored: got %h want %h", obs, exp); end
    // a stale pulse alongside a redirect to a new line is ignored
    redir = 1'b1; rpc = 16'h0400; chg = 1'b1; tick();
    redir = 1'b0; chg = 1'b0;
    exps = {1'b0, 16'h0400, 16'h0400};
    vectors++;
    if (obs_s !== exps) begin miscompares++; $display("FAIL stale_pulse: got %h want %h", obs_s, exps); end
    tick();
    vectors++;
    if (ivalid !== 1'b0) begin miscompares++; $display("FAIL stale_pulse_next: got %b want 0", ivalid); end
  endtask

  task automatic test_redirect_hit;
    logic [48:0] exp;
    do_reset();
    data = 64'h4444_3333_2222_1111; chg = 1'b1; tick();
    chg = 1'b0; ready = 1'b1; tick();
    exp = {1'b1, 16'h2222, 16'd258, 16'h0100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hit_pre: got %h want %h", obs, exp); end
    redir = 1'b1; rpc = 16'h0107; tick();
    redir = 1'b0; ready = 1'b0;
    exp = {1'b1, 16'h4444, 16'd262, 16'h0100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hit_same_line: got %h want %h", obs, exp); end
  endtask

  task automatic test_timeout;
    logic [48:0] exp;
    do_reset();
    data = 64'h0008_0007_0006_0005;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      vectors++;
      if (ivalid !== 1'b0) begin miscompares++; $display("FAIL to_wait_%0d: got %b want 0", i, ivalid); end
    end
    tick();
    exp = {1'b1, 16'h0005, 16'd256, 16'h0100};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL to_capture: got %h want %h", obs, exp); end
    // redirect while fetching restarts the wait
    redir = 1'b1; rpc = 16'h0300; tick();
    redir = 1'b0; tick(); tick();
    redir = 1'b1; rpc = 16'h0302; tick();
    redir = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      vectors++;
      if (ivalid !== 1'b0) begin miscompares++; $display("FAIL to_restart_wait_%0d: got %b want 0", i, ivalid); end
    end
    tick();
    exp = {1'b1, 16'h0006, 16'h0302, 16'h0300};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL to_restart_capture: got %h want %h", obs, exp); end
  endtask

  task automatic test_wrap;
    logic [48:0] exp;
    logic [32:0] exps;
    do_reset();
    redir = 1'b1; rpc = 16'hFFFE; tick();
    redir = 1'b0;
    data = 64'h9999_8888_7777_6666; chg = 1'b1; tick();
    chg = 1'b0;
    exp = {1'b1, 16'h9999, 16'hFFFE, 16'hFFF8};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL wrap_top: got %h want %h", obs, exp); end
    ready = 1'b1; tick(); ready = 1'b0;
    exps = {1'b0, 16'h0000, 16'h0000};
    vectors++;
    if (obs_s !== exps) begin miscompares++; $display("FAIL wrap_zero: got %h want %h", obs_s, exps); end
    data = 64'hD4D4_C3C3_B2B2_A1A1; chg = 1'b1; tick();
    chg = 1'b0;
    exp = {1'b1, 16'hA1A1, 16'h0000, 16'h0000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL wrap_fill0: got %h want %h", obs, exp); end
    ready = 1'b1; redir = 1'b1; rpc = 16'h0004; tick();
    ready = 1'b0; redir = 1'b0;
    exp = {1'b1, 16'hC3C3, 16'h0004, 16'h0000};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL redir_with_hs: got %h want %h", obs, exp); end
  endtask

  task automatic test_random;
    logic [15:0] m_pc;
    logic [63:0] m_line;
    logic [12:0] m_tag;
    bit          m_have, m_srv;
    int          m_wait, sh;
    logic [15:0] t;
    logic [48:0] exp;
    do_reset();
    m_pc = RPC; m_line = 64'd0; m_tag = 13'd0; m_have = 0; m_srv = 0; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      redir = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = {m_pc[15:3], 3'($urandom)};
        1:       rpc = m_pc + 16'($urandom_range(0, 31));
        default: rpc = 16'($urandom);
      endcase
      ready = ($urandom_range(0, 9) < 7);
      chg   = m_srv ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
      data  = mem_line(m_pc[15:3]);

      if (rst) begin
        m_pc = RPC; m_line = 64'd0; m_tag = 13'd0; m_have = 0; m_srv = 0; m_wait = 0;
      end else if (redir) begin
        t = rpc - (rpc % 16'd2);
        m_pc = t;
        if (m_have && (int'(t) / 8 == int'(m_tag))) begin
          m_srv = 1;
        end else begin
          m_have = 0; m_srv = 0; m_wait = 0;
        end
      end else if (!m_srv) begin
        if (chg || m_wait == TO - 1) begin
          m_line = data; m_tag = 13'(int'(m_pc) / 8);
          m_have = 1; m_srv = 1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else if (ready) begin
        if (m_pc % 16'd8 == 16'd6) begin
          m_have = 0; m_srv = 0; m_wait = 0;
        end
        m_pc = m_pc + 16'd2;
      end

      tick();
      sh  = 16 * ((int'(m_pc) % 8) / 2);
      exp = {m_srv, m_line[sh +: 16], m_pc, m_pc - (m_pc % 16'd8)};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL random_c%0d: got %h want %h", c, obs, exp); end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_redirect_miss();
    test_redirect_hit();
    test_timeout();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
